// File: rtl/signal_histogram_pkg.sv
// Shared definitions for the signal histogram: FSM states and pipeline depth.
package signal_histogram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACQ   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Cycles after the last sample needed to flush S1 -> S2 -> S3 write.
  localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/signal_histogram_ram.sv
// Simple dual-port bin RAM: one write port, one registered read-first read port.
module signal_histogram_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write and registered read; a same-address read returns the old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/signal_histogram.sv
// Histogram accumulator for a decimated signed sample stream. A start pulse
// clears every bin, then a programmed number of samples is binned into RAM
// through a 3-stage read-modify-write pipeline; counts are read back afterwards.
module signal_histogram
  import signal_histogram_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int BIN_BITS    = 8,
  parameter int COUNT_WIDTH = 32,
  parameter int DECIM_WIDTH = 16,
  parameter int NSAMP_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   start_i,
  input  logic [DECIM_WIDTH-1:0] decim_i,
  input  logic [NSAMP_WIDTH-1:0] nsamples_i,
  input  logic [BIN_BITS-1:0]    rd_addr_i,
  output logic [COUNT_WIDTH-1:0] rd_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   sat_o,
  output logic [NSAMP_WIDTH-1:0] taken_o
);

  state_e                 state;
  logic [BIN_BITS-1:0]    clr_addr;
  logic [DECIM_WIDTH-1:0] dval, dcnt;
  logic [NSAMP_WIDTH-1:0] nsamp, taken, taken_nx;
  logic [1:0]             drain_cnt;
  logic                   take, dcnt_last, rd_en_q;

  // Offset-binary view of the sample: flipping the sign bit makes bins monotonic.
  logic [WIDTH-1:0]       data_ob;
  logic [BIN_BITS-1:0]    bin_in;
  assign data_ob = {~data_i[WIDTH-1], data_i[WIDTH-2:0]};
  assign bin_in  = data_ob[WIDTH-1 -: BIN_BITS];

  // Increment pipeline registers; S4 holds the write retired last cycle.
  logic                   s1_vld, s2_vld, s3_vld, s4_vld;
  logic [BIN_BITS-1:0]    s1_bin, s2_bin, s3_bin, s4_bin;
  logic [COUNT_WIDTH-1:0] s3_cnt, s4_cnt, cnt_cur, cnt_inc;

  logic                   ram_we;
  logic [BIN_BITS-1:0]    ram_waddr, ram_raddr;
  logic [COUNT_WIDTH-1:0] ram_wdata, ram_rdata;

  assign busy_o    = (state == ST_CLEAR) || (state == ST_ACQ) || (state == ST_DRAIN);
  assign done_o    = (state == ST_DONE);
  assign taken_o   = taken;
  assign taken_nx  = taken + 1'b1;
  assign dcnt_last = (dcnt == dval - 1'b1);
  assign take      = (state == ST_ACQ) && (dcnt == '0) && (taken != nsamp);

  // FSM, decimation/sample counters and sticky saturation flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      clr_addr  <= '0;
      dval      <= '0;
      dcnt      <= '0;
      nsamp     <= '0;
      taken     <= '0;
      drain_cnt <= '0;
      sat_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            dval     <= (decim_i == '0) ? DECIM_WIDTH'(1) : decim_i;
            nsamp    <= nsamples_i;
            taken    <= '0;
            sat_o    <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) begin
            state <= ST_ACQ;
            dcnt  <= '0;
          end
        end
        ST_ACQ: begin
          dcnt <= dcnt_last ? '0 : dcnt + 1'b1;
          if (take) taken <= taken_nx;
          if ((nsamp == '0) || (take && (taken_nx == nsamp))) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
      if (s3_vld && (&s3_cnt)) sat_o <= 1'b1;
    end
  end

  // Newest in-flight count for the S2 bin wins over the stale RAM read.
  always_comb begin
    cnt_cur = ram_rdata;
    if (s4_vld && (s4_bin == s2_bin)) cnt_cur = s4_cnt;
    if (s3_vld && (s3_bin == s2_bin)) cnt_cur = s3_cnt;
    cnt_inc = (&cnt_cur) ? cnt_cur : cnt_cur + 1'b1;
  end

  // Advance the read-modify-write pipeline every cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_vld <= 1'b0; s2_vld <= 1'b0; s3_vld <= 1'b0; s4_vld <= 1'b0;
      s1_bin <= '0;   s2_bin <= '0;   s3_bin <= '0;   s4_bin <= '0;
      s3_cnt <= '0;   s4_cnt <= '0;
    end else begin
      s1_vld <= take;   s1_bin <= bin_in;
      s2_vld <= s1_vld; s2_bin <= s1_bin;
      s3_vld <= s2_vld; s3_bin <= s2_bin; s3_cnt <= cnt_inc;
      s4_vld <= s3_vld; s4_bin <= s3_bin; s4_cnt <= s3_cnt;
    end
  end

  // CLEAR owns the write port; afterwards S3 writes back incremented counts.
  assign ram_we    = (state == ST_CLEAR) || s3_vld;
  assign ram_waddr = (state == ST_CLEAR) ? clr_addr : s3_bin;
  assign ram_wdata = (state == ST_CLEAR) ? '0 : s3_cnt;
  assign ram_raddr = busy_o ? s1_bin : rd_addr_i;

  signal_histogram_ram #(
    .AW (BIN_BITS),
    .DW (COUNT_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Readout data is only meaningful if the address was presented while idle/done.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rd_en_q <= 1'b0;
    else         rd_en_q <= (state == ST_IDLE) || (state == ST_DONE);
  end

  assign rd_data_o = (rd_en_q && !busy_o) ? ram_rdata : '0;

endmodule

// File: tb/tb_signal_histogram.sv
// Directed bench for signal_histogram: a default instance plus a 4-bit-count
// instance for saturation behaviour.
module tb_signal_histogram;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] data;
  logic        start_a, start_b;
  logic [15:0] decim;
  logic [31:0] nsamp;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data_a, taken_a, taken_b;
  logic [3:0]  rd_data_b;
  logic        busy_a, done_a, sat_a, busy_b, done_b, sat_b;

  int n_assert = 0;
  int n_fail   = 0;
  int dmode    = 0;   // 0 hold, 1 ramp +1 per cycle, 2 alternate extremes

  always #5 clk = ~clk;

  signal_histogram u_dut (
    .clk_i(clk), .rstn_i(rstn), .data_i(data), .start_i(start_a), .decim_i(decim),
    .nsamples_i(nsamp), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .busy_o(busy_a),
    .done_o(done_a), .sat_o(sat_a), .taken_o(taken_a)
  );

  signal_histogram #(.COUNT_WIDTH(4)) u_sat (
    .clk_i(clk), .rstn_i(rstn), .data_i(data), .start_i(start_b), .decim_i(decim),
    .nsamples_i(nsamp), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .busy_o(busy_b),
    .done_o(done_b), .sat_o(sat_b), .taken_o(taken_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (dmode == 1) data = data + 16'd1;
    else if (dmode == 2) data = (data == 16'h8000) ? 16'h7fff : 16'h8000;
  endtask

  task automatic rd_a(input int a, output logic [31:0] v);
    rd_addr = 8'(a);
    tick();
    v = rd_data_a;
  endtask

  task automatic rd_b(input int a, output logic [3:0] v);
    rd_addr = 8'(a);
    tick();
    v = rd_data_b;
  endtask

  task automatic sum_a(output logic [31:0] s);
    logic [31:0] v;
    s = 0;
    for (int i = 0; i < 256; i++) begin
      rd_a(i, v);
      s = s + v;
    end
  endtask

  task automatic wait_done(input string tag, input bit sel);
    int n = 0;
    while (!(sel ? done_b : done_a) && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 64'(sel ? done_b : done_a), 64'd1);
  endtask

  task automatic wait_taken(input string tag, input logic [31:0] t);
    int n = 0;
    while (taken_a < t && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 64'(taken_a >= t), 64'd1);
  endtask

  logic [31:0] v, s;
  logic [3:0]  vb;

  initial begin
    rstn = 1'b0; data = '0; start_a = 0; start_b = 0;
    decim = 16'd1; nsamp = 32'd0; rd_addr = '0;
    tick(); tick();
    chk("rst_busy",  busy_a,    0);
    chk("rst_done",  done_a,    0);
    chk("rst_sat",   sat_a,     0);
    chk("rst_taken", taken_a,   0);
    chk("rst_rdata", rd_data_a, 0);
    rstn = 1'b1;
    tick();

    // 1: constant zero, D=1, four back-to-back hits on bin 128
    data = 16'd0; decim = 16'd1; nsamp = 32'd4;
    start_a = 1; tick(); start_a = 0;
    chk("t1_busy_clear", busy_a, 1);
    chk("t1_done_clear", done_a, 0);
    wait_done("t1_done", 0);
    chk("t1_taken", taken_a, 4);
    chk("t1_sat",   sat_a,   0);
    chk("t1_busy_done", busy_a, 0);
    rd_a(128, v); chk("t1_bin128", v, 4);
    sum_a(s);     chk("t1_total",  s, 4);

    // 2: ramp, D=3; ACQ cycle 0 sees 254 -> samples 254,257,260,263,266
    decim = 16'd3; nsamp = 32'd5;
    data = 16'hfffd; dmode = 1;
    start_a = 1; tick(); start_a = 0;
    wait_done("t2_done", 0);
    dmode = 0;
    chk("t2_taken", taken_a, 5);
    rd_a(128, v); chk("t2_bin128", v, 1);
    rd_a(129, v); chk("t2_bin129", v, 4);
    sum_a(s);     chk("t2_total",  s, 5);

    // 3: alternating extremes, D=1, ten samples
    decim = 16'd1; nsamp = 32'd10;
    data = 16'h8000; dmode = 2;
    start_a = 1; tick(); start_a = 0;
    wait_done("t3_done", 0);
    dmode = 0;
    rd_a(0, v);   chk("t3_bin0",   v, 5);
    rd_a(255, v); chk("t3_bin255", v, 5);
    rd_a(128, v); chk("t3_bin128", v, 0);

    // 4: 4-bit counters saturate at 15; rerun with zero samples clears
    data = 16'd0; decim = 16'd0; nsamp = 32'd20;
    start_b = 1; tick(); start_b = 0;
    wait_done("t4_done", 1);
    chk("t4_taken", taken_b, 20);
    chk("t4_sat",   sat_b,   1);
    rd_b(128, vb); chk("t4_bin128", vb, 15);
    nsamp = 32'd0;
    start_b = 1; tick(); start_b = 0;
    chk("t4_sat_cleared", sat_b, 0);
    wait_done("t4_done2", 1);
    chk("t4_taken0",  taken_b, 0);
    chk("t4_sat_off", sat_b,   0);
    rd_b(128, vb); chk("t4_bin128_clr", vb, 0);

    // 5: fresh data on main DUT, start pulse during ACQ must be ignored
    data = 16'h1234; decim = 16'd2; nsamp = 32'd6;
    start_a = 1; tick(); start_a = 0;
    wait_taken("t5_reach2", 32'd2);
    start_a = 1; tick(); start_a = 0;
    chk("t5_busy_acq", busy_a, 1);
    wait_done("t5_done", 0);
    chk("t5_taken", taken_a, 6);
    rd_a(146, v); chk("t5_bin146", v, 6);
    rd_a(0, v);   chk("t5_bin0",   v, 0);
    rd_a(255, v); chk("t5_bin255", v, 0);

    // 6: reset mid-ACQ, then a clean run
    decim = 16'd1; nsamp = 32'd100;
    start_a = 1; tick(); start_a = 0;
    wait_taken("t6_reach3", 32'd3);
    rstn = 1'b0;
    #1;
    chk("t6_busy",  busy_a,  0);
    chk("t6_done",  done_a,  0);
    chk("t6_taken", taken_a, 0);
    tick();
    rstn = 1'b1;
    tick();
    data = 16'hffff; nsamp = 32'd7;
    start_a = 1; tick(); start_a = 0;
    wait_done("t6_done2", 0);
    chk("t6_taken2", taken_a, 7);
    rd_a(127, v); chk("t6_bin127", v, 7);
    sum_a(s);     chk("t6_total",  s, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
